// File: rtl/md_pkg.sv
// md_pkg: shared encodings, FSM states and constants for the HI/LO
// multiply/divide unit and its iterative divider.
package md_pkg;

    // Operation encodings as presented on the op input.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Number of restoring-division steps, one quotient bit per step.
    localparam int DIV_ITER = 32;

    // Width of the shared multiply/divide down-counter.
    localparam int CNT_W = 5;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } md_state_t;

    // Magnitude of a two's complement word when en is set, raw value otherwise.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Two's complement negation when en is set, raw value otherwise.
    function automatic logic [31:0] negIf(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned radix-2 restoring divider. A load captures the
// operands, then each enabled cycle produces one quotient bit. After 32
// enabled cycles o_quot/o_rem hold the unsigned quotient and remainder.
// Signs are handled by the caller.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // Partial remainder shifted left with the next dividend bit, and the trial subtraction.
    always_comb begin
        w_shift = {r_rem, r_quot[31]};
        w_diff  = w_shift - {1'b0, r_divisor};
        w_fits  = ~w_diff[32];
    end

    // Operand capture on load, then one restoring step per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= 32'd0;
            r_divisor <= i_divisor;
        end else if (i_en) begin
            if (w_fits) begin
                r_rem  <= w_diff[31:0];
                r_quot <= {r_quot[30:0], 1'b1};
            end else begin
                r_rem  <= w_shift[31:0];
                r_quot <= {r_quot[30:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: MIPS-style HI/LO multiply/divide unit. Multiplies complete
// MUL_LAT edges after acceptance using a product registered at the
// accepting edge; divides run 32 restoring steps in div_iter followed by
// one sign-fix cycle. mthi/mtlo writes are taken only while idle.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [63:0]        r_prod;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_done;

    logic               w_accept;
    logic [63:0]        w_aExt;
    logic [63:0]        w_bExt;
    logic [63:0]        w_prod;
    logic               w_signedDivIn;
    logic [31:0]        w_aAbs;
    logic [31:0]        w_bAbs;
    logic               w_divLoad;
    logic               w_divStep;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic               w_signedDiv;
    logic               w_divByZero;
    logic [31:0]        w_fixQuot;
    logic [31:0]        w_fixRem;

    // Start acceptance and the hazard-unit busy; reset forces busy low at once.
    always_comb begin
        w_accept = (r_state == IDLE) & start & ~flush;
        busy     = ~rst & ((r_state != IDLE) | w_accept);
    end

    // Operand extension for the 64-bit product; sign extension gives the signed product in the low 64 bits.
    always_comb begin
        w_aExt = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        w_bExt = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        w_prod = w_aExt * w_bExt;
    end

    // Divider operand magnitudes and load/step controls.
    always_comb begin
        w_signedDivIn = (op == MD_DIV);
        w_aAbs        = abs32(a, w_signedDivIn);
        w_bAbs        = abs32(b, w_signedDivIn);
        w_divLoad     = w_accept & op[1];
        w_divStep     = (r_state == DIV);
    end

    div_iter u_divIter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_divLoad),
        .i_en       (w_divStep),
        .i_dividend (w_aAbs),
        .i_divisor  (w_bAbs),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Sign fix-up of the unsigned divider result, with the divide-by-zero override.
    always_comb begin
        w_signedDiv = (r_op == MD_DIV);
        w_divByZero = (r_b == 32'd0);
        w_fixQuot   = negIf(w_quot, w_signedDiv & (r_a[31] ^ r_b[31]));
        w_fixRem    = negIf(w_rem, w_signedDiv & r_a[31]);
        if (w_divByZero) begin
            w_fixQuot = 32'hFFFF_FFFF;
            w_fixRem  = r_a;
        end
    end

    // Controller FSM with registered HI/LO and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= MD_MULT;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_prod  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= op;
                        r_a    <= a;
                        r_b    <= b;
                        r_prod <= w_prod;
                        if (op[1]) begin
                            r_state <= DIV;
                            r_cnt   <= CNT_W'(DIV_ITER - 1);
                        end else begin
                            r_state <= MUL;
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                        end
                    end else begin
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                MUL: begin
                    if (r_cnt == '0) begin
                        r_hi    <= r_prod[63:32];
                        r_lo    <= r_prod[31:0];
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    r_hi    <= w_fixRem;
                    r_lo    <= w_fixQuot;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: randomized and directed bench for md_ctrl. A transaction-level
// model tracks HI/LO, the remaining latency of the operation in flight and
// the done pulse; a negedge process compares the DUT against it every cycle.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        flush = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [31:0] pHi;
    logic [31:0] pLo;
    int          mLeft;
    logic        mDone;
    logic        mBusy;

    md_ctrl #(.MUL_LAT(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of an operation, returned as {HI, LO}.
    function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: an accepted op completes after a fixed number of edges; mthi/mtlo only while idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mHi   <= 32'd0;
            mLo   <= 32'd0;
            mLeft <= 0;
            mDone <= 1'b0;
            pHi   <= 32'd0;
            pLo   <= 32'd0;
        end else begin
            mDone <= 1'b0;
            if (mLeft > 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mHi   <= pHi;
                    mLo   <= pLo;
                    mDone <= 1'b1;
                end
            end else if (start && !flush) begin
                {pHi, pLo} <= refResult(op, a, b);
                mLeft      <= op[1] ? DIV_LAT : LAT;
            end else begin
                if (hi_we) mHi <= wdata;
                if (lo_we) mLo <= wdata;
            end
        end
    end

    assign mBusy = !rst && ((mLeft != 0) || (start && !flush));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
        checkOutput("done", {31'd0, done}, {31'd0, mDone});
        checkOutput("hi", hi, mHi);
        checkOutput("lo", lo, mLo);
    end

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] av,
                                 input logic [31:0] bv, input logic f, input logic hw,
                                 input logic lw, input logic [31:0] wd);
        start = s;
        op    = o;
        a     = av;
        b     = bv;
        flush = f;
        hi_we = hw;
        lo_we = lw;
        wdata = wd;
    endtask

    task automatic cycle();
        @(negedge clk);
        #2;
    endtask

    // Issue one op, optionally with a mid-run start, and wait for done counting busy cycles.
    task automatic runOp(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic midStart, input logic hw, output int busyCnt);
        bit found;
        busyCnt = 0;
        found   = 1'b0;
        applyStimulus(1'b1, o, av, bv, 1'b0, hw, 1'b0, 32'h0000_DEAD);
        cycle();
        applyStimulus(1'b0, o, av, bv, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 100 && !found; i++) begin
            if (done === 1'b1) begin
                found = 1'b1;
            end else begin
                if (busy === 1'b1) busyCnt++;
                if (midStart && i == 5)
                    applyStimulus(1'b1, MD_MULTU, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0);
                else
                    applyStimulus(1'b0, o, av, bv, 1'b0, 1'b0, 1'b0, 32'd0);
                cycle();
            end
        end
        checkOutput("doneSeen", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        #1 rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        checkOutput("rstHi", hi, 32'd0);
        checkOutput("rstLo", lo, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);

        runOp(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, bc);
        checkOutput("multHi", hi, 32'hFFFF_FFFF);
        checkOutput("multLo", lo, 32'hFFFF_FFF1);
        checkOutput("multBusyCycles", 32'(bc), 32'd3);
        cycle();
        checkOutput("multDoneOnce", {31'd0, done}, 32'd0);

        runOp(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, bc);
        checkOutput("divuLo", lo, 32'd14);
        checkOutput("divuHi", hi, 32'd2);
        checkOutput("divuBusyCycles", 32'(bc), 32'd33);
        cycle();
        checkOutput("divuNoMidRun", {31'd0, busy}, 32'd0);

        runOp(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, bc);
        checkOutput("divNegLo", lo, 32'hFFFF_FFFD);
        checkOutput("divNegHi", hi, 32'hFFFF_FFFF);

        runOp(MD_DIV, 32'd7, 32'd0, 1'b0, 1'b0, bc);
        checkOutput("divZeroLo", lo, 32'hFFFF_FFFF);
        checkOutput("divZeroHi", hi, 32'd7);
        checkOutput("divZeroBusyCycles", 32'(bc), 32'd33);

        // Reset in the middle of a divide.
        applyStimulus(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle();
        applyStimulus(1'b0, MD_DIV, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (9) cycle();
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstHi", hi, 32'd0);
        checkOutput("midRstLo", lo, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_1234);
        cycle();
        checkOutput("mthiAfterRst", hi, 32'h0000_1234);
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Flushed start has no effect.
        applyStimulus(1'b1, MD_DIV, 32'd9, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("flushBusy", {31'd0, busy}, 32'd0);
        cycle();
        checkOutput("flushStillIdle", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // mthi + mtlo together, then start wins over mthi.
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001);
        cycle();
        checkOutput("mthiBoth", hi, 32'hA5A5_0001);
        checkOutput("mtloBoth", lo, 32'hA5A5_0001);
        runOp(MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b1, bc);
        checkOutput("startPrioHi", hi, 32'd0);
        checkOutput("startPrioLo", lo, 32'd6);

        // Randomized traffic checked by the per-cycle compare process.
        for (int n = 0; n < 2500; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            hi_we = ($urandom_range(0, 4) == 0);
            lo_we = ($urandom_range(0, 4) == 0);
            wdata = $urandom;
            cycle();
        end
        rst = 1'b0;
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (40) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
